// File: rtl/matrix_arb_lock.sv
// matrix_arb_lock: least-recently-granted matrix arbiter with packet-level grant locking.
// The matrix rotates only when a grant completes (tail accepted, or every flit when unlocked).
module matrix_arb_lock #(
    parameter int IN_N     = 5,
    parameter int LOCK_EN  = 1,
    parameter int ARB_MODE = 0,
    localparam int W       = IN_N > 1 ? $clog2(IN_N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IN_N-1:0] req_i,
    input  logic [IN_N-1:0] last_i,
    input  logic            ack_i,
    output logic [IN_N-1:0] grant_oh_o,
    output logic [W-1:0]    grant_o,
    output logic            grant_vld_o,
    output logic            lock_o
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    owner_q, owner_d;
    logic [IN_N-1:0] m_q [IN_N];
    logic [IN_N-1:0] lrg_oh, fix_oh, idle_oh, col;
    logic [W-1:0]    idle_idx;
    logic            upd;

    // i wins when no other requester holds priority over it (column i of the matrix)
    always_comb begin
        lrg_oh = '0;
        col    = '0;
        for (int i = 0; i < IN_N; i++) begin
            for (int j = 0; j < IN_N; j++) col[j] = m_q[j][i];
            lrg_oh[i] = req_i[i] & ~|(req_i & col & ~(IN_N'(1) << i));
        end
        fix_oh  = req_i & (~req_i + IN_N'(1));
        idle_oh = ARB_MODE == 1 ? fix_oh : lrg_oh;
        idle_idx = '0;
        for (int i = 0; i < IN_N; i++)
            if (idle_oh[i]) idle_idx = W'(i);
    end

    assign grant_oh_o  = state_q == LOCKED ? IN_N'(1) << owner_q : idle_oh;
    assign grant_o     = state_q == LOCKED ? owner_q : idle_idx;
    assign grant_vld_o = state_q == LOCKED ? req_i[owner_q] : |req_i;
    assign lock_o      = LOCK_EN != 0 && state_q == LOCKED;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        upd     = 1'b0;
        if (state_q == IDLE) begin
            if (ack_i && |req_i) begin
                if (LOCK_EN != 0 && !last_i[idle_idx]) begin
                    state_d = LOCKED;
                    owner_d = idle_idx;
                end else begin
                    upd = 1'b1;
                end
            end
        end else if (ack_i && req_i[owner_q] && last_i[owner_q]) begin
            state_d = IDLE;
            upd     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // completed grant k drops to lowest priority: row k cleared, column k set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < IN_N; i++)
                for (int j = 0; j < IN_N; j++)
                    m_q[i][j] <= j > i;
        end else if (upd && ARB_MODE == 0) begin
            for (int i = 0; i < IN_N; i++)
                if (i == int'(grant_o)) m_q[i] <= '0;
                else m_q[i][grant_o] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_matrix_arb_lock.sv
// tb_matrix_arb_lock: directed vectors against hand-computed grants for the locking matrix arbiter.
module tb_matrix_arb_lock;
    logic       clk = 1'b0;
    logic       rst;
    logic       ack;
    logic [4:0] req, last;

    logic [4:0] oh0, oh1, oh2;
    logic [2:0] g0, g1, g2;
    logic       v0, v1, v2, l0, l1, l2;
    logic [0:0] oh3, g3;
    logic       v3, l3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matrix_arb_lock #(.IN_N(5), .LOCK_EN(1), .ARB_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last), .ack_i(ack),
        .grant_oh_o(oh0), .grant_o(g0), .grant_vld_o(v0), .lock_o(l0));

    matrix_arb_lock #(.IN_N(5), .LOCK_EN(1), .ARB_MODE(1)) dut_fix (
        .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last), .ack_i(ack),
        .grant_oh_o(oh1), .grant_o(g1), .grant_vld_o(v1), .lock_o(l1));

    matrix_arb_lock #(.IN_N(5), .LOCK_EN(0), .ARB_MODE(0)) dut_nolock (
        .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last), .ack_i(ack),
        .grant_oh_o(oh2), .grant_o(g2), .grant_vld_o(v2), .lock_o(l2));

    matrix_arb_lock #(.IN_N(1), .LOCK_EN(1), .ARB_MODE(0)) dut_one (
        .clk_i(clk), .rst_i(rst), .req_i(req[0:0]), .last_i(last[0:0]), .ack_i(ack),
        .grant_oh_o(oh3), .grant_o(g3), .grant_vld_o(v3), .lock_o(l3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive on the falling edge, settle, then leave checks to the caller before the rising edge
    task automatic cyc(input logic [4:0] r, input logic [4:0] l, input logic a);
        @(negedge clk);
        req  = r;
        last = l;
        ack  = a;
        #1;
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 3, 4, 0};
        rst = 1'b1; req = '0; last = '0; ack = 1'b0;
        cyc(5'b00000, 5'b00000, 1'b0);
        chk("rst_oh", oh0, 0);
        chk("rst_g", g0, 0);
        chk("rst_vld", v0, 0);
        chk("rst_lock", l0, 0);
        rst = 1'b0;
        foreach (seq[i]) begin
            cyc(5'b11111, 5'b11111, 1'b1);
            chk("rr_g", g0, seq[i]);
            chk("rr_vld", v0, 1);
            chk("rr_lock", l0, 0);
        end
        chk("rr_oh", oh0, 5'b00001);
        for (int i = 0; i < 4; i++) begin
            cyc(5'b00101, i == 3 ? 5'b00100 : 5'b00000, 1'b1);
            chk("pkt_g", g0, 2);
            chk("pkt_lock", l0, i != 0);
        end
        cyc(5'b00101, 5'b00000, 1'b0);
        chk("pkt_after_g", g0, 0);
        chk("pkt_after_lock", l0, 0);
        cyc(5'b00100, 5'b00000, 1'b1);
        chk("stall_head_g", g0, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b00101, 5'b00100, 1'b0);
            chk("stall_g", g0, 2);
            chk("stall_vld", v0, 1);
            chk("stall_lock", l0, 1);
        end
        cyc(5'b00001, 5'b00100, 1'b1);
        chk("bubble_g", g0, 2);
        chk("bubble_vld", v0, 0);
        chk("bubble_oh", oh0, 5'b00100);
        chk("bubble_lock", l0, 1);
        cyc(5'b00101, 5'b00100, 1'b1);
        chk("tail_g", g0, 2);
        chk("tail_lock", l0, 1);
        cyc(5'b00101, 5'b00000, 1'b0);
        chk("post_tail_g", g0, 0);
        chk("post_tail_lock", l0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b00110, 5'b00000, 1'b0);
            chk("noack_g", g0, 1);
        end
        cyc(5'b00110, 5'b11111, 1'b1);
        chk("ack_g", g0, 1);
        cyc(5'b00110, 5'b00000, 1'b0);
        chk("rot_g", g0, 2);
        cyc(5'b01000, 5'b00000, 1'b1);
        chk("r3_head_g", g0, 3);
        cyc(5'b01000, 5'b00000, 1'b0);
        chk("r3_lock", l0, 1);
        rst = 1'b1;
        cyc(5'b11000, 5'b00000, 1'b0);
        rst = 1'b0;
        cyc(5'b11000, 5'b00000, 1'b0);
        chk("midrst_lock", l0, 0);
        chk("midrst_g", g0, 3);
        cyc(5'b10010, 5'b00000, 1'b0);
        chk("midrst_prio_g", g0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(5'b10100, 5'b11111, 1'b1);
            chk("fix_g", g1, 2);
            chk("fix_vld", v1, 1);
        end
        chk("fix_oh", oh1, 5'b00100);
        rst = 1'b1;
        cyc(5'b00000, 5'b00000, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(5'b00011, 5'b00000, 1'b1);
            chk("nolock_g", g2, i % 2);
            chk("nolock_lock", l2, 0);
            chk("one_lock", l3, i != 0);
            chk("one_g", g3, 0);
            chk("one_vld", v3, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
